// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/execute controller for the 8-bit core.
// Owns the program counter, fetches instruction words over a req/ack
// handshake, holds them in the instruction register, issues a one-cycle
// execute strobe and applies the decoder's PC-load requests.
module fetch_sequencer #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16,
  parameter int TimeoutCycles     = 15
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         run,
  input  logic                         step,
  output logic                         mem_req,
  output logic [PC_WIDTH-1:0]          mem_adr,
  input  logic [PROGRAM_DataWidth-1:0] mem_data,
  input  logic                         mem_ack,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  input  logic                         cnt_wr_en,
  input  logic                         add_offset,
  input  logic [PC_WIDTH-1:0]          literal_adr,
  output logic                         exec_en,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [1:0]                   state,
  output logic                         mem_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    ERROR = 2'b11
  } state_t;

  localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [PC_WIDTH-1:0]            r_pc;
  logic [PROGRAM_DataWidth-1:0]   r_instr;
  logic [7:0]                     r_tcnt;
  logic [PC_WIDTH-1:0]            w_pc_next;

  // Next-state logic; a step pulse is only honoured in IDLE, so it is
  // consumed implicitly and never queued.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (run || step) w_next_state = FETCH;
      FETCH: begin
        if (mem_ack)                    w_next_state = EXEC;  // ack beats timeout
        else if (r_tcnt == TimeoutLast) w_next_state = ERROR;
      end
      EXEC:  w_next_state = run ? FETCH : IDLE;
      ERROR: w_next_state = ERROR;
      default: w_next_state = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // PC target for the end of EXEC: relative, absolute or sequential (wraps silently).
  always_comb begin
    w_pc_next = r_pc + PC_WIDTH'(1);
    if (cnt_wr_en) begin
      if (add_offset) w_pc_next = r_pc + literal_adr;
      else            w_pc_next = literal_adr;
    end
  end

  // Program counter: changes only at the end of EXEC.
  always_ff @(posedge clk) begin
    if (!reset_n)             r_pc <= '0;
    else if (r_state == EXEC) r_pc <= w_pc_next;
  end

  // Instruction register: captures the fetched word on ack; an ack during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n)                          r_instr <= '0;
    else if (r_state == FETCH && mem_ack)  r_instr <= mem_data;
  end

  // Fetch wait counter: counts un-acked FETCH cycles, cleared by ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tcnt <= '0;
    end else if (r_state == FETCH) begin
      if (mem_ack) r_tcnt <= '0;
      else         r_tcnt <= r_tcnt + 8'd1;
    end
  end

  // Outputs decoded from registered state only.
  assign mem_req     = (r_state == FETCH);
  assign exec_en     = (r_state == EXEC);
  assign mem_err     = (r_state == ERROR);
  assign mem_adr     = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign state       = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: linear step sequence with
// hand-computed expectations checked by immediate assertions.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        step;
  logic        mem_req;
  logic [7:0]  mem_adr;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic [15:0] instruction;
  logic        cnt_wr_en;
  logic        add_offset;
  logic [7:0]  literal_adr;
  logic        exec_en;
  logic [7:0]  pc;
  logic [1:0]  state;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] S_IDLE = 2'b00, S_FETCH = 2'b01, S_EXEC = 2'b10, S_ERROR = 2'b11;

  fetch_sequencer #(.PC_WIDTH(8), .PROGRAM_DataWidth(16), .TimeoutCycles(15)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .step        (step),
    .mem_req     (mem_req),
    .mem_adr     (mem_adr),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .instruction (instruction),
    .cnt_wr_en   (cnt_wr_en),
    .add_offset  (add_offset),
    .literal_adr (literal_adr),
    .exec_en     (exec_en),
    .pc          (pc),
    .state       (state),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting in FETCH: `waits` un-acked cycles, then ack,
  // then one EXEC cycle with the given decoder outputs.
  task automatic do_instr(input logic [15:0] word, input int waits,
                          input logic cwe, input logic ao, input logic [7:0] lit,
                          input logic [7:0] adr, input logic [7:0] exp_pc,
                          input logic run_after);
    check("fetch_state", state, S_FETCH);
    check("fetch_adr", mem_adr, adr);
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      tick();
      check("wait_req", mem_req, 1'b1);
      check("wait_adr_stable", mem_adr, adr);
    end
    mem_ack  = 1'b1;
    mem_data = word;
    tick();
    mem_ack  = 1'b0;
    mem_data = 16'hDEAD;
    check("exec_state", state, S_EXEC);
    check("exec_en_hi", exec_en, 1'b1);
    check("exec_instr", instruction, word);
    check("exec_pc_held", pc, adr);
    cnt_wr_en   = cwe;
    add_offset  = ao;
    literal_adr = lit;
    run         = run_after;
    tick();
    cnt_wr_en   = 1'b0;
    add_offset  = 1'b0;
    literal_adr = 8'h00;
    check("exec_en_lo", exec_en, 1'b0);
    check("next_pc", pc, exp_pc);
    check("next_adr", mem_adr, exp_pc);
    check("after_state", state, run_after ? S_FETCH : S_IDLE);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; step = 1'b0; mem_ack = 1'b0; mem_data = 16'h0000;
    cnt_wr_en = 1'b0; add_offset = 1'b0; literal_adr = 8'h00;
    tick(); tick();

    // Reset state.
    check("rst_state", state, S_IDLE);
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instruction, 16'h0000);
    check("rst_exec_en", exec_en, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_err", mem_err, 1'b0);

    // Free run with zero-wait memory.
    reset_n = 1'b1;
    run     = 1'b1;
    tick();
    do_instr(16'h0800, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1);
    do_instr(16'h0000, 0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h02, 1'b1);
    do_instr(16'h0000, 0, 1'b0, 1'b0, 8'h00, 8'h02, 8'h03, 1'b1);
    check("pc_after_3", pc, 8'h03);
    do_instr(16'h1111, 0, 1'b0, 1'b0, 8'h00, 8'h03, 8'h04, 1'b1);
    do_instr(16'h2222, 0, 1'b0, 1'b0, 8'h00, 8'h04, 8'h05, 1'b1);

    // Absolute GOTO, relative branch backwards, add_offset without cnt_wr_en.
    do_instr(16'h2820, 0, 1'b1, 1'b0, 8'h20, 8'h05, 8'h20, 1'b1);
    do_instr(16'h2810, 0, 1'b1, 1'b0, 8'h10, 8'h20, 8'h10, 1'b1);
    do_instr(16'h3CFE, 0, 1'b1, 1'b1, 8'hFE, 8'h10, 8'h0E, 1'b1);
    do_instr(16'h0000, 0, 1'b0, 1'b1, 8'h55, 8'h0E, 8'h0F, 1'b1);

    // PC wrap by increment and by relative offset.
    do_instr(16'h28FF, 0, 1'b1, 1'b0, 8'hFF, 8'h0F, 8'hFF, 1'b1);
    do_instr(16'h0000, 0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b1);
    check("wrap_no_err", mem_err, 1'b0);
    do_instr(16'h28F0, 0, 1'b1, 1'b0, 8'hF0, 8'h00, 8'hF0, 1'b1);
    do_instr(16'h3C20, 0, 1'b1, 1'b1, 8'h20, 8'hF0, 8'h10, 1'b1);

    // Three wait states; run dropped during EXEC completes the instruction.
    do_instr(16'h4444, 3, 1'b0, 1'b0, 8'h00, 8'h10, 8'h11, 1'b0);
    tick();
    check("idle_hold", state, S_IDLE);
    check("idle_no_req", mem_req, 1'b0);

    // Single step; a second step during FETCH is ignored.
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_fetch", state, S_FETCH);
    step = 1'b1;
    tick();
    step = 1'b0;
    do_instr(16'h5555, 0, 1'b0, 1'b0, 8'h00, 8'h11, 8'h12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("step_one_only", state, S_IDLE);
      check("step_no_exec", exec_en, 1'b0);
    end

    // Fetch timeout: 15 un-acked FETCH cycles then ERROR.
    run = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) tick();
    check("to_cycle15_fetch", state, S_FETCH);
    tick();
    check("to_state", state, S_ERROR);
    check("to_mem_err", mem_err, 1'b1);
    check("to_mem_req", mem_req, 1'b0);
    check("to_exec_en", exec_en, 1'b0);
    mem_ack = 1'b1; mem_data = 16'h9999; step = 1'b1;
    tick(); tick(); tick();
    mem_ack = 1'b0; step = 1'b0;
    check("err_sticky", state, S_ERROR);
    check("err_pc_frozen", pc, 8'h12);
    check("err_instr_frozen", instruction, 16'h5555);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("err_rst_state", state, S_IDLE);
    check("err_rst_pc", pc, 8'h00);
    check("err_rst_mem_err", mem_err, 1'b0);

    // Ack exactly on the 15th FETCH cycle wins over the timeout.
    tick();
    do_instr(16'h1234, 14, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0);
    check("ack15_no_err", mem_err, 1'b0);

    // Reset during FETCH with ack arriving in the reset cycle.
    run = 1'b1;
    tick();
    run = 1'b0;
    check("rf_fetch", state, S_FETCH);
    tick(); tick(); tick();
    mem_ack = 1'b1; mem_data = 16'hBEEF; reset_n = 1'b0;
    tick();
    mem_ack = 1'b0; reset_n = 1'b1;
    check("rf_state", state, S_IDLE);
    check("rf_instr", instruction, 16'h0000);
    check("rf_pc", pc, 8'h00);
    check("rf_exec_en", exec_en, 1'b0);
    tick();
    check("rf_idle_after", state, S_IDLE);
    check("rf_no_exec_after", exec_en, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
